fd_reg: RTL and testbench
=========================

Name: fd_reg

Overview:
- F/D pipeline register of the five-stage MIPS core. It sits directly downstream of the PC/fetch stage.
- Captures the fetch PC and instruction word each cycle.
- Performs fetch-address exception detection (AdEL) and records whether the fetched instruction is in a branch delay slot.
- Honours stall, flush and interrupt/exception request (Req), so the D stage always sees a well-defined instruction, or a bubble with a correct macroscopic PC.

Parameters:
- TEXT_BASE, 32'h0000_3000, lowest legal instruction address.
- TEXT_END, 32'h0000_6FFC, highest legal instruction address (inclusive).
- HANDLER_PC, 32'h0000_4180, PC loaded into D on Req.
- EXC_ADEL, 5'd4, ExcCode for instruction-fetch address error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  register enable; 0 = stall (hold).
- flush  in  1  replace fetched instruction with bubble (e.g. ERET / likely-branch cancel).
- Req  in  1  exception/interrupt request from CP0; overrides all but reset.
- PC_F  in  32  fetch PC.
- Instr_F  in  32  instruction word read at PC_F.
- BD_F  in  1  fetched instruction is in a delay slot (branch/jump currently in D).
- PC_D  out  32  registered PC.
- Instr_D  out  32  registered instruction (0 = nop).
- ExcCode_D  out  5  pending exception code (0 = none).
- BD_D  out  1  registered delay-slot flag.
- valid_D  out  1  1 = real instruction, 0 = bubble.
- stall_cnt  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Asynchronous reset (reset=0) sets PC_D=TEXT_BASE, Instr_D=0, ExcCode_D=0, BD_D=0, valid_D=0 immediately, independent of clk.
- All other updates occur on the rising edge of clk, in this priority order:
  1. Req=1: load bubble with PC_D=HANDLER_PC, Instr_D=0, ExcCode_D=0, BD_D=0, valid_D=0. Req overrides en=0 and flush.
  2. en=0: hold all outputs unchanged. A stall overrides flush, so a flush request during a stall is lost; the hazard unit must re-assert it.
  3. flush=1: bubble with PC_D=PC_F, Instr_D=0, ExcCode_D=0, BD_D=0, valid_D=0.
  4. Otherwise: normal load, PC_D=PC_F, BD_D=BD_F, valid_D=1.
- AdEL check on normal load: if PC_F[1:0]!=0, or PC_F<TEXT_BASE, or PC_F>TEXT_END:
  - ExcCode_D=EXC_ADEL and Instr_D=0, so the faulting word is never decoded.
  - valid_D=1 still, because the exception must be carried to M.
- Otherwise ExcCode_D=0 and Instr_D=Instr_F.
- Range comparisons are unsigned 32-bit. PC_F=TEXT_END is legal; TEXT_END+4 faults.
- Latency: one cycle from F inputs to D outputs. There is no combinational path from inputs to outputs.
- Outputs are registered only; there is no internal state machine beyond the hold/load selection. Behaviour is defined by the priority list above.

Optional Feature:
- Macro: FD_STALL_CNT_EN.
- Defined:
  - stall_cnt increments on every rising edge with reset=1, Req=0, en=0.
  - It saturates at 32'hFFFF_FFFF.
  - It clears asynchronously on reset and is unaffected by flush.
- Not defined: stall_cnt is tied to 32'h0 and no counter flops are generated.

Test Plan:
- Release reset (reset 0->1) with en=1, PC_F=0x3000, Instr_F=0x3C011234 -> next edge gives PC_D=0x3000, Instr_D=0x3C011234, valid_D=1, ExcCode_D=0. Before that edge, outputs hold reset values (PC_D=0x3000, valid_D=0).
- Hold en=0 for 3 cycles while PC_F changes 0x3004 -> 0x3008 -> 0x300C -> PC_D stays 0x3000 throughout. With FD_STALL_CNT_EN, stall_cnt=3. Raising en then loads PC_F.
- PC_F=0x3002, then 0x7000, then 0x2FFC (en=1) -> each cycle gives ExcCode_D=4, Instr_D=0, valid_D=1. PC_F=0x6FFC -> ExcCode_D=0.
- flush=1, en=1, PC_F=0x3010 -> PC_D=0x3010, Instr_D=0, valid_D=0. Same with en=0 -> outputs hold.
- Req=1 together with en=0 and flush=1, PC_F=0x3020 -> PC_D=0x4180, Instr_D=0, BD_D=0, valid_D=0.
- BD_F=1 with normal load -> BD_D=1. Assert reset=0 mid-cycle, between edges -> all outputs go to reset values without waiting for clk; stall_cnt=0.

Source files
------------

// File: rtl/fd_reg.sv
// fd_reg: F/D pipeline register with AdEL check, stall/flush/Req handling.
// Optional stall counter enabled by `define FD_STALL_CNT_EN.
//
// Ports:
//   clk        rising-edge clock
//   reset      async active-low reset
//   en         0 = stall (hold outputs)
//   flush      load a bubble carrying PC_F
//   Req        CP0 exception/interrupt: bubble at HANDLER_PC
//   PC_F       fetch PC
//   Instr_F    fetched instruction word
//   BD_F       fetched instruction is in a delay slot
//   PC_D       registered PC
//   Instr_D    registered instruction (0 = nop)
//   ExcCode_D  pending exception code (0 = none)
//   BD_D       registered delay-slot flag
//   valid_D    1 = real instruction, 0 = bubble
//   stall_cnt  saturating stall-cycle counter (0 when feature off)
module fd_reg #(
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
  parameter logic [31:0] TEXT_END   = 32'h0000_6FFC,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic        Req,
  input  logic [31:0] PC_F,
  input  logic [31:0] Instr_F,
  input  logic        BD_F,
  output logic [31:0] PC_D,
  output logic [31:0] Instr_D,
  output logic [4:0]  ExcCode_D,
  output logic        BD_D,
  output logic        valid_D,
  output logic [31:0] stall_cnt
);

  logic adel;

  // Misaligned or outside the text segment (unsigned compares).
  assign adel = (PC_F[1:0] != 2'b00)
             || (PC_F < TEXT_BASE)
             || (PC_F > TEXT_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_D      <= TEXT_BASE;
      Instr_D   <= 32'h0;
      ExcCode_D <= 5'd0;
      BD_D      <= 1'b0;
      valid_D   <= 1'b0;
    end else if (Req) begin
      PC_D      <= HANDLER_PC;
      Instr_D   <= 32'h0;
      ExcCode_D <= 5'd0;
      BD_D      <= 1'b0;
      valid_D   <= 1'b0;
    end else if (!en) begin
      // Stall wins over flush; a flush seen here is dropped.
      PC_D      <= PC_D;
      Instr_D   <= Instr_D;
      ExcCode_D <= ExcCode_D;
      BD_D      <= BD_D;
      valid_D   <= valid_D;
    end else if (flush) begin
      PC_D      <= PC_F;
      Instr_D   <= 32'h0;
      ExcCode_D <= 5'd0;
      BD_D      <= 1'b0;
      valid_D   <= 1'b0;
    end else begin
      PC_D      <= PC_F;
      BD_D      <= BD_F;
      // A faulting fetch stays valid so the exception reaches M,
      // but its word is replaced by a nop and never decoded.
      valid_D   <= 1'b1;
      if (adel) begin
        Instr_D   <= 32'h0;
        ExcCode_D <= EXC_ADEL;
      end else begin
        Instr_D   <= Instr_F;
        ExcCode_D <= 5'd0;
      end
    end
  end

`ifdef FD_STALL_CNT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 32'h0;
    end else if (!Req && !en && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign stall_cnt = cnt;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fd_reg.sv
// tb_fd_reg: directed bench for fd_reg with a cycle model and compare.
// Literal checks pin the model at the points the test plan names.
module tb_fd_reg;

  localparam logic [31:0] TB_BASE = 32'h0000_3000;
  localparam logic [31:0] TB_END  = 32'h0000_6FFC;
  localparam logic [31:0] TB_HPC  = 32'h0000_4180;

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic        Req;
  logic [31:0] PC_F;
  logic [31:0] Instr_F;
  logic        BD_F;
  logic [31:0] PC_D;
  logic [31:0] Instr_D;
  logic [4:0]  ExcCode_D;
  logic        BD_D;
  logic        valid_D;
  logic [31:0] stall_cnt;

  int n_tests;
  int n_fail;
  bit chk_on;

  fd_reg dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .Req       (Req),
    .PC_F      (PC_F),
    .Instr_F   (Instr_F),
    .BD_F      (BD_F),
    .PC_D      (PC_D),
    .Instr_D   (Instr_D),
    .ExcCode_D (ExcCode_D),
    .BD_D      (BD_D),
    .valid_D   (valid_D),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic [4:0]  m_exc;
  logic        m_bd;
  logic        m_v;
  longint      m_stalls;

  function automatic bit bad_pc(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < TB_BASE) || (pc > TB_END);
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef FD_STALL_CNT_EN
    if (m_stalls > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    return m_stalls[31:0];
`else
    return 32'h0;
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc     <= TB_BASE;
      m_ins    <= 32'h0;
      m_exc    <= 5'd0;
      m_bd     <= 1'b0;
      m_v      <= 1'b0;
      m_stalls <= 0;
    end else begin
      if (!Req && !en) m_stalls <= m_stalls + 1;
      if (Req) begin
        m_pc  <= TB_HPC;
        m_ins <= 32'h0;
        m_exc <= 5'd0;
        m_bd  <= 1'b0;
        m_v   <= 1'b0;
      end else if (en && flush) begin
        m_pc  <= PC_F;
        m_ins <= 32'h0;
        m_exc <= 5'd0;
        m_bd  <= 1'b0;
        m_v   <= 1'b0;
      end else if (en) begin
        m_pc  <= PC_F;
        m_bd  <= BD_F;
        m_v   <= 1'b1;
        m_ins <= bad_pc(PC_F) ? 32'h0 : Instr_F;
        m_exc <= bad_pc(PC_F) ? 5'd4 : 5'd0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_pc", PC_D, m_pc);
      chk("m_ins", Instr_D, m_ins);
      chk("m_exc", {27'd0, ExcCode_D}, {27'd0, m_exc});
      chk("m_bd", {31'd0, BD_D}, {31'd0, m_bd});
      chk("m_v", {31'd0, valid_D}, {31'd0, m_v});
      chk("m_cnt", stall_cnt, exp_cnt());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_lit(input logic [31:0] v);
`ifdef FD_STALL_CNT_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_on  = 1'b0;
    reset   = 1'b0;
    en      = 1'b1;
    flush   = 1'b0;
    Req     = 1'b0;
    PC_F    = 32'h3000;
    Instr_F = 32'h3C01_1234;
    BD_F    = 1'b0;
    tick();
    tick();
    chk_on = 1'b1;
    chk("rst_pc", PC_D, 32'h3000);
    chk("rst_v", {31'd0, valid_D}, 32'd0);
    reset = 1'b1;
    #1;
    chk("pre_pc", PC_D, 32'h3000);
    chk("pre_v", {31'd0, valid_D}, 32'd0);
    tick();
    chk("ld_pc", PC_D, 32'h3000);
    chk("ld_ins", Instr_D, 32'h3C01_1234);
    chk("ld_v", {31'd0, valid_D}, 32'd1);
    chk("ld_exc", {27'd0, ExcCode_D}, 32'd0);

    en = 1'b0;
    PC_F = 32'h3004; tick(); chk("st1", PC_D, 32'h3000);
    PC_F = 32'h3008; tick(); chk("st2", PC_D, 32'h3000);
    PC_F = 32'h300C; tick(); chk("st3", PC_D, 32'h3000);
    chk("st_cnt", stall_cnt, cnt_lit(32'd3));
    en = 1'b1;
    Instr_F = 32'h2000_0001;
    tick();
    chk("unst", PC_D, 32'h300C);
    chk("unst_ins", Instr_D, 32'h2000_0001);

    PC_F = 32'h3002; tick();
    chk("mis_exc", {27'd0, ExcCode_D}, 32'd4);
    chk("mis_ins", Instr_D, 32'h0);
    chk("mis_v", {31'd0, valid_D}, 32'd1);
    PC_F = 32'h7000; tick();
    chk("hi_exc", {27'd0, ExcCode_D}, 32'd4);
    chk("hi_ins", Instr_D, 32'h0);
    PC_F = 32'h2FFC; tick();
    chk("lo_exc", {27'd0, ExcCode_D}, 32'd4);
    chk("lo_v", {31'd0, valid_D}, 32'd1);
    PC_F = 32'h6FFC; tick();
    chk("end_exc", {27'd0, ExcCode_D}, 32'd0);
    chk("end_ins", Instr_D, 32'h2000_0001);

    flush = 1'b1;
    PC_F = 32'h3010; tick();
    chk("fl_pc", PC_D, 32'h3010);
    chk("fl_ins", Instr_D, 32'h0);
    chk("fl_v", {31'd0, valid_D}, 32'd0);
    en = 1'b0;
    PC_F = 32'h3014; tick();
    chk("flst_pc", PC_D, 32'h3010);

    Req = 1'b1;
    PC_F = 32'h3020; tick();
    chk("rq_pc", PC_D, 32'h4180);
    chk("rq_ins", Instr_D, 32'h0);
    chk("rq_bd", {31'd0, BD_D}, 32'd0);
    chk("rq_v", {31'd0, valid_D}, 32'd0);
    chk("rq_cnt", stall_cnt, cnt_lit(32'd4));

    Req = 1'b0; flush = 1'b0; en = 1'b1;
    BD_F = 1'b1;
    PC_F = 32'h3024;
    Instr_F = 32'h1234_5678;
    tick();
    chk("bd_bd", {31'd0, BD_D}, 32'd1);
    chk("bd_ins", Instr_D, 32'h1234_5678);

    #3;
    reset = 1'b0;
    #1;
    chk("ar_pc", PC_D, 32'h3000);
    chk("ar_ins", Instr_D, 32'h0);
    chk("ar_bd", {31'd0, BD_D}, 32'd0);
    chk("ar_v", {31'd0, valid_D}, 32'd0);
    chk("ar_cnt", stall_cnt, 32'h0);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      en      = (i % 3) != 1;
      flush   = (i % 5) == 2;
      Req     = (i == 9);
      BD_F    = i[0];
      PC_F    = 32'h3000 + 32'(i * 6);
      Instr_F = 32'hA500_0000 + 32'(i);
      tick();
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
